cluster_accum: RTL



---
 rtl/cluster_accum_pkg.sv | 28 ++
 rtl/cluster_accum_div.sv | 79 +++++++
 rtl/cluster_accum.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cluster_accum_pkg.sv
// Shared definitions for the cluster accumulator endpoint.
// Holds the point geometry, the cluster count, the controller state
// encoding and a helper that extracts one coordinate from a packed point.
// Dimension 0 (x) sits in the MSBs of a packed point and the last
// dimension in the LSBs, matching the packing used by cluster_CE.
package cluster_accum_pkg;

  localparam int dim         = 3;
  localparam int data_range  = 255;
  localparam int dim_size    = $clog2(data_range);
  localparam int center_size = dim * dim_size;
  localparam int axis_size   = $clog2(dim);
  localparam int k           = 8;
  localparam int id_size     = $clog2(k);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    LOAD  = 2'd1,
    DIV   = 2'd2,
    EMIT  = 2'd3
  } state_t;

  function automatic logic [dim_size-1:0] coord(input logic [center_size-1:0] p,
                                                input int d);
    return p[center_size-1-d*dim_size -: dim_size];
  endfunction

endpackage

// File: rtl/cluster_accum_div.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset (control state only)
//   start      load dividend/divisor and begin
//   dividend   dvd_size-bit numerator
//   divisor    dvs_size-bit denominator, never zero
//   busy       iterations in progress
//   done       one-cycle pulse, quotient valid from this cycle on
//   quotient   floor(dividend/divisor), held until the next start
// done arrives dvd_size+1 cycles after the start cycle.
module seq_divider #(
  parameter int dvd_size = 24,
  parameter int dvs_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [dvd_size-1:0] dividend,
  input  logic [dvs_size-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [dvd_size-1:0] quotient
);

  localparam int step_w = $clog2(dvd_size + 1);

  logic [step_w-1:0]   steps;
  logic [dvs_size-1:0] rem;
  logic [dvs_size-1:0] dvs;
  logic [dvd_size-1:0] quo;
  logic [dvs_size:0]   shifted;
  logic [dvs_size:0]   diff;

  // Remainder stays below the divisor, so one extra bit is enough for
  // the trial subtraction; its MSB doubles as the borrow.
  always_comb begin
    shifted = {rem, quo[dvd_size-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      steps <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        steps <= step_w'(dvd_size);
      end else if (busy) begin
        steps <= steps - 1'b1;
        if (steps == step_w'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (busy) begin
      if (!diff[dvs_size]) begin
        rem <= diff[dvs_size-1:0];
        quo <= {quo[dvd_size-2:0], 1'b1};
      end else begin
        rem <= shifted[dvs_size-1:0];
        quo <= {quo[dvd_size-2:0], 1'b0};
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/cluster_accum.sv
// cluster_accum: result-side endpoint of the kd-tree cluster network.
// Accumulates per-cluster coordinate sums and point counts during a
// k-means pass; on flush, computes each cluster's floored mean and
// streams the k new centers out in cluster order.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pt_valid/pt_ready   point/id handshake (ready only while accumulating)
//   point, best_id      packed point and the cluster it was assigned to
//   flush               end of pass, honoured only while accumulating
//   c_valid/c_ready     center handshake
//   c_id, c_center      cluster index and its new center
//   c_empty             cluster saw no points; c_center is zero
//   done                one-cycle pulse after the last center is accepted
//   overflow            sticky, a point was dropped on a full counter
module cluster_accum
  import cluster_accum_pkg::*;
#(
  parameter int cnt_size = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  input  logic [center_size-1:0] point,
  input  logic [id_size-1:0]     best_id,
  input  logic                   flush,
  output logic                   c_valid,
  input  logic                   c_ready,
  output logic [id_size-1:0]     c_id,
  output logic [center_size-1:0] c_center,
  output logic                   c_empty,
  output logic                   done,
  output logic                   overflow
);

  localparam int sum_size = dim_size + cnt_size;

  logic [sum_size-1:0] acc [k][dim];
  logic [cnt_size-1:0] count [k];
  logic [dim_size-1:0] res [dim];

  state_t               state;
  state_t               state_next;
  logic [id_size-1:0]   idx;
  logic [axis_size-1:0] axis;

  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [sum_size-1:0] quotient;

  function automatic logic cnt_full(input logic [cnt_size-1:0] c);
    return c == '1;
  endfunction

  // The mean never exceeds data_range; the clamp only guards the width.
  function automatic logic [dim_size-1:0] sat_coord(input logic [sum_size-1:0] q);
    if (q > sum_size'(data_range)) return dim_size'(data_range);
    return q[dim_size-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      ACCUM: if (flush) state_next = LOAD;
      LOAD: begin
        if (count[idx] == '0) begin
          state_next = EMIT;
        end else begin
          div_start  = 1'b1;
          state_next = DIV;
        end
      end
      DIV: begin
        if (div_done && !div_busy)
          state_next = (axis == axis_size'(dim - 1)) ? EMIT : LOAD;
      end
      EMIT: begin
        if (c_ready)
          state_next = (idx == id_size'(k - 1)) ? ACCUM : LOAD;
      end
      default: state_next = ACCUM;
    endcase
  end

  assign pt_ready = (state == ACCUM);
  assign c_valid  = (state == EMIT);
  assign c_id     = idx;

  always_comb begin
    c_center = '0;
    for (int dd = 0; dd < dim; dd++)
      c_center[center_size-1-dd*dim_size -: dim_size] = res[dd];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ii = 0; ii < k; ii++) begin
        count[ii] <= '0;
        for (int dd = 0; dd < dim; dd++) acc[ii][dd] <= '0;
      end
      for (int dd = 0; dd < dim; dd++) res[dd] <= '0;
      idx      <= '0;
      axis     <= '0;
      c_empty  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ACCUM: begin
          // A point arriving together with flush still belongs to this pass.
          if (pt_valid && pt_ready) begin
            if (cnt_full(count[best_id])) begin
              overflow <= 1'b1;
            end else begin
              count[best_id] <= count[best_id] + 1'b1;
              for (int dd = 0; dd < dim; dd++)
                acc[best_id][dd] <= acc[best_id][dd] + sum_size'(coord(point, dd));
            end
          end
          if (flush) begin
            idx  <= '0;
            axis <= '0;
          end
        end
        LOAD: begin
          if (count[idx] == '0) begin
            c_empty <= 1'b1;
            for (int dd = 0; dd < dim; dd++) res[dd] <= '0;
          end else begin
            c_empty <= 1'b0;
          end
        end
        DIV: begin
          if (div_done && !div_busy) begin
            res[axis] <= sat_coord(quotient);
            if (axis != axis_size'(dim - 1)) axis <= axis + 1'b1;
          end
        end
        EMIT: begin
          if (c_ready) begin
            count[idx] <= '0;
            for (int dd = 0; dd < dim; dd++) acc[idx][dd] <= '0;
            if (idx == id_size'(k - 1)) begin
              done <= 1'b1;
            end else begin
              idx  <= idx + 1'b1;
              axis <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  seq_divider #(
    .dvd_size (sum_size),
    .dvs_size (cnt_size)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc[idx][axis]),
    .divisor  (count[idx]),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

endmodule
